// File: rtl/cobi_pkg.sv
// Shared types and helpers for the COBI scan-chain readout engine.
package cobi_pkg;

  localparam int CHIP_SCAN_BITS = 504;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_GAP,
    S_SHIFT_HI,
    S_SHIFT_LO,
    S_DONE
  } scan_state_e;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_phase_timer.sv
// Loadable down-counter; last is high on the final cycle of a loaded phase.
module scan_phase_timer
  import cobi_pkg::*;
#(
  parameter int MAX_COUNT = 4,
  localparam int W = clog2_min1(MAX_COUNT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt;

  // load_val is phase length minus one, so the phase spans load_val+1 cycles.
  always_ff @(posedge clk) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/scan_chain_ctrl.sv
// Multi-sample scan-chain readout: drives sample/scanout clocks and emits one
// NUM_CHAINS-bit BRAM write per shifted bit, addressed {sample_idx, bit_addr}.
module scan_chain_ctrl
  import cobi_pkg::*;
#(
  parameter int NUM_CHAINS       = 4,
  parameter int SCAN_CHAIN_DEPTH = 2 * CHIP_SCAN_BITS,
  parameter int HALF_PERIOD      = 2,
  parameter int SAMPLE_PULSE     = 4,
  parameter int MAX_SAMPLES      = 16,
  localparam int BW = clog2_min1(SCAN_CHAIN_DEPTH),
  localparam int SW = clog2_min1(MAX_SAMPLES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SW:0]           num_samples,
  input  logic                  abort,
  input  logic [NUM_CHAINS-1:0] scanout_data,
  output logic                  ready,
  output logic                  busy,
  output logic                  sample_clk,
  output logic                  scanout_clk,
  output logic                  out_valid,
  output logic [NUM_CHAINS-1:0] out_data,
  output logic [BW-1:0]         bit_addr,
  output logic [SW-1:0]         sample_idx,
  output logic                  done
);

  localparam int TMAX = (SAMPLE_PULSE > HALF_PERIOD) ? SAMPLE_PULSE : HALF_PERIOD;
  localparam int TW   = clog2_min1(TMAX);
  localparam logic [TW-1:0] SP_LD      = TW'(SAMPLE_PULSE - 1);
  localparam logic [TW-1:0] HP_LD      = TW'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] LAST_SHIFT = BW'((SCAN_CHAIN_DEPTH > 1) ? SCAN_CHAIN_DEPTH - 2 : 0);
  localparam logic [SW:0]   MAX_NS     = (SW+1)'(MAX_SAMPLES);

  scan_state_e   state;
  logic [BW-1:0] bit_cnt;
  logic [SW-1:0] cur_idx;
  logic [SW-1:0] ns_q;
  logic [SW-1:0] ns_last;
  logic          accept;
  logic          eos;
  logic          more;
  logic          tmr_load;
  logic          tmr_last;
  logic [TW-1:0] tmr_val;

  // Stored as the index of the final sample, after clamping to 1..MAX_SAMPLES.
  always_comb begin
    ns_last = '0;
    if (num_samples == '0)         ns_last = '0;
    else if (num_samples > MAX_NS) ns_last = SW'(MAX_SAMPLES - 1);
    else                           ns_last = SW'(num_samples - 1'b1);
  end

  assign accept = start && !abort;
  assign more   = (cur_idx != ns_q);
  assign eos    = tmr_last &&
                  (((state == S_GAP) && (SCAN_CHAIN_DEPTH == 1)) ||
                   ((state == S_SHIFT_LO) && (bit_cnt == LAST_SHIFT)));

  // Every phase boundary reloads the timer for the phase about to begin.
  always_comb begin
    tmr_load = (state == S_IDLE) ? accept : tmr_last;
    tmr_val  = ((state == S_IDLE) || (eos && more)) ? SP_LD : HP_LD;
  end

  scan_phase_timer #(.MAX_COUNT(TMAX)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last     (tmr_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ready       <= 1'b1;
      busy        <= 1'b0;
      sample_clk  <= 1'b0;
      scanout_clk <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      bit_addr    <= '0;
      sample_idx  <= '0;
      done        <= 1'b0;
      bit_cnt     <= '0;
      cur_idx     <= '0;
      ns_q        <= '0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if ((state != S_IDLE) && abort) begin
        state       <= S_IDLE;
        ready       <= 1'b1;
        busy        <= 1'b0;
        sample_clk  <= 1'b0;
        scanout_clk <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              state      <= S_SAMPLE;
              ready      <= 1'b0;
              busy       <= 1'b1;
              sample_clk <= 1'b1;
              cur_idx    <= '0;
              bit_cnt    <= '0;
              ns_q       <= ns_last;
            end
          end
          S_SAMPLE: begin
            if (tmr_last) begin
              state      <= S_GAP;
              sample_clk <= 1'b0;
            end
          end
          S_GAP, S_SHIFT_LO: begin
            if (tmr_last) begin
              out_valid  <= 1'b1;
              out_data   <= scanout_data;
              sample_idx <= cur_idx;
              if (state == S_GAP) begin
                bit_addr <= '0;
              end else begin
                bit_addr <= bit_cnt + 1'b1;
                bit_cnt  <= bit_cnt + 1'b1;
              end
              if (eos && more) begin
                // Next sample starts immediately; its pulse overlaps this write.
                state      <= S_SAMPLE;
                sample_clk <= 1'b1;
                cur_idx    <= cur_idx + 1'b1;
                bit_cnt    <= '0;
              end else if (eos) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state       <= S_SHIFT_HI;
                scanout_clk <= 1'b1;
              end
            end
          end
          S_SHIFT_HI: begin
            if (tmr_last) begin
              state       <= S_SHIFT_LO;
              scanout_clk <= 1'b0;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: cycle-arithmetic reference model plus a shift-register chain model.
module tb_scan_chain_ctrl;

  localparam int NC = 4;
  localparam int D  = 8;
  localparam int HP = 2;
  localparam int SP = 3;
  localparam int MX = 16;
  localparam int L  = SP + HP + (D - 1) * 2 * HP;   // 33 cycles per sample

  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic [4:0] num_samples;
  logic [NC-1:0] scanout_data;
  logic ready, busy, sample_clk, scanout_clk, out_valid, done;
  logic [NC-1:0] out_data;
  logic [2:0] bit_addr;
  logic [3:0] sample_idx;

  logic start2, abort2;
  logic [4:0] ns2;
  logic [NC-1:0] sdata2;
  logic ready2, busy2, sclk2, oclk2, valid2, done2;
  logic [NC-1:0] data2;
  logic [9:0] addr2;
  logic [3:0] idx2;

  always #5 clk = ~clk;

  scan_chain_ctrl #(.NUM_CHAINS(NC), .SCAN_CHAIN_DEPTH(D), .HALF_PERIOD(HP),
                    .SAMPLE_PULSE(SP), .MAX_SAMPLES(MX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples), .abort(abort),
    .scanout_data(scanout_data), .ready(ready), .busy(busy), .sample_clk(sample_clk),
    .scanout_clk(scanout_clk), .out_valid(out_valid), .out_data(out_data),
    .bit_addr(bit_addr), .sample_idx(sample_idx), .done(done));

  scan_chain_ctrl #(.HALF_PERIOD(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .num_samples(ns2), .abort(abort2),
    .scanout_data(sdata2), .ready(ready2), .busy(busy2), .sample_clk(sclk2),
    .scanout_clk(oclk2), .out_valid(valid2), .out_data(data2),
    .bit_addr(addr2), .sample_idx(idx2), .done(done2));

  int checks = 0, errors = 0;
  int cyc = 0, seed = 0, run_id = 0;

  function automatic logic [D-1:0] pat(input int s, input int c, input int sd);
    logic [7:0] base [4];
    base = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    if (sd == 0 && s == 0) return base[c];
    return 8'((s * 59) ^ (c * 113) ^ (sd * 29) ^ 8'h6B);
  endfunction

  // Chain model: parallel load on sample_clk rise, shift toward bit 0 on scanout_clk rise.
  logic [NC-1:0][D-1:0] chain = '0;
  int ld_cnt = 0, seen_id = 0;
  always @(posedge sample_clk or posedge scanout_clk) begin
    if (sample_clk) begin
      if (seen_id != run_id) begin seen_id = run_id; ld_cnt = 0; end
      for (int c = 0; c < NC; c++) chain[c] = pat(ld_cnt, c, seed);
      ld_cnt++;
    end else begin
      for (int c = 0; c < NC; c++) chain[c] = chain[c] >> 1;
    end
  end
  always_comb begin
    scanout_data = '0;
    for (int c = 0; c < NC; c++) scanout_data[c] = chain[c][0];
  end

  // Reference model: r = cycles since the accepting edge; outputs follow from r alone.
  bit m_busy = 1'b0;
  int r = 0, m_n = 1;
  logic e_sclk = 0, e_oclk = 0, e_vld = 0, e_done = 0;
  logic [NC-1:0] h_data = '0;
  int h_bit = 0, h_idx = 0;
  int mp, mq, mpp, mk;
  logic [D-1:0] mpv;
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_busy = 0; h_data = '0; h_bit = 0; h_idx = 0;
    end else if (m_busy && abort) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (start && !abort) begin
        m_busy = 1; r = 1; run_id++;
        m_n = (num_samples == 0) ? 1 : ((num_samples > MX) ? MX : int'(num_samples));
      end
    end else if (r == m_n * L + 1) begin
      m_busy = 0;
    end else begin
      r++;
    end
    e_sclk = 0; e_oclk = 0; e_vld = 0; e_done = 0;
    if (m_busy) begin
      if (r <= m_n * L) begin
        mp = (r - 1) % L;
        e_sclk = (mp < SP);
        e_oclk = (mp >= SP + HP) && (((mp - SP - HP) / HP) % 2 == 0);
      end
      if (r >= 2) begin
        mq = r - 1; mpp = (mq - 1) % L; mk = mpp - (SP + HP - 1);
        if (mk >= 0 && mk % (2 * HP) == 0) begin
          e_vld = 1; h_bit = mk / (2 * HP); h_idx = (mq - 1) / L;
          for (int c = 0; c < NC; c++) begin
            mpv = pat(h_idx, c, seed);
            h_data[c] = mpv[h_bit];
          end
        end
      end
      e_done = (r == m_n * L + 1);
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  int wr_cnt = 0, done_cnt = 0, done_cyc = 0, sclk_rise = 0, sclk_hi = 0, oclk_rise = 0;
  int last_ba = 0, last_si = 0, rise_a = 0, rise_b = 0;
  logic [NC-1:0] d_b0 = '0, d_b2 = '0;
  logic p_sclk = 0, p_oclk = 0, p_oclk2 = 0;
  int w2 = 0, r2 = 0, last_ba2 = 0, d2_cnt = 0;
  int c0 = 0;

  // One cycle: compare everything against the model at negedge, then step to posedge+1.
  task automatic tick();
    @(negedge clk);
    chk("ready", ready, !m_busy);
    chk("busy", busy, m_busy);
    chk("sample_clk", sample_clk, e_sclk);
    chk("scanout_clk", scanout_clk, e_oclk);
    chk("out_valid", out_valid, e_vld);
    chk("done", done, e_done);
    chk("out_data", out_data, h_data);
    chk("bit_addr", bit_addr, h_bit);
    chk("sample_idx", sample_idx, h_idx);
    if (out_valid) begin
      wr_cnt++; last_ba = bit_addr; last_si = sample_idx;
      if (bit_addr == 0 && sample_idx == 0) d_b0 = out_data;
      if (bit_addr == 2 && sample_idx == 0) d_b2 = out_data;
    end
    if (sample_clk && !p_sclk) begin sclk_rise++; rise_a = rise_b; rise_b = cyc; end
    if (sample_clk) sclk_hi++;
    if (scanout_clk && !p_oclk) oclk_rise++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    p_sclk = sample_clk; p_oclk = scanout_clk;
    if (valid2) begin w2++; last_ba2 = addr2; chk("d2_out_data", data2, 4'hA); end
    if (oclk2 && !p_oclk2) r2++;
    if (done2) d2_cnt++;
    p_oclk2 = oclk2;
    @(posedge clk); #1;
  endtask

  task automatic launch(input int ns, input int sd);
    for (int i = 0; i < 50 && !ready; i++) tick();
    seed = sd; num_samples = 5'(ns); start = 1; c0 = cyc;
    tick();
    start = 0;
  endtask

  task automatic run(input int ns, input int sd, input int budget);
    int d0;
    d0 = done_cnt;
    launch(ns, sd);
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    chk("run_completes", done_cnt != d0, 1);
  endtask

  int w0, s0, o0, h0, dn0;

  initial begin
    rst_n = 0; start = 0; abort = 0; num_samples = 0;
    start2 = 0; abort2 = 0; ns2 = 5'd1; sdata2 = 4'hA;
    tick(); tick();
    chk("rst_ready", ready, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    rst_n = 1;
    tick();

    // 1: single sample, fixed pattern
    w0 = wr_cnt; s0 = sclk_rise; o0 = oclk_rise; h0 = sclk_hi;
    run(1, 0, 60);
    chk("t1_writes", wr_cnt - w0, 8);
    chk("t1_scan_rises", oclk_rise - o0, 7);
    chk("t1_sample_pulses", sclk_rise - s0, 1);
    chk("t1_sample_width", sclk_hi - h0, 3);
    chk("t1_done_cycle", done_cyc - c0, 34);
    chk("t1_last_bit", last_ba, 7);
    chk("t1_bit0_data", d_b0, 4'b0101);
    chk("t1_bit2_data", d_b2, 4'b0111);
    chk("t1_ready_after", ready, 1);

    // 2: three samples, pattern changes per sample
    w0 = wr_cnt; s0 = sclk_rise; dn0 = done_cnt;
    run(3, 5, 150);
    chk("t2_writes", wr_cnt - w0, 24);
    chk("t2_sample_pulses", sclk_rise - s0, 3);
    chk("t2_pulse_spacing", rise_b - rise_a, 33);
    chk("t2_done_count", done_cnt - dn0, 1);
    chk("t2_last_idx", last_si, 2);

    // 3: clamping of num_samples
    w0 = wr_cnt;
    run(0, 7, 60);
    chk("t3_zero_writes", wr_cnt - w0, 8);
    chk("t3_zero_done_cycle", done_cyc - c0, 34);
    w0 = wr_cnt;
    run(31, 8, 600);
    chk("t3_clamp_writes", wr_cnt - w0, 128);
    chk("t3_clamp_last_idx", last_si, 15);
    chk("t3_clamp_done_cycle", done_cyc - c0, 16 * 33 + 1);

    // 4: abort in SHIFT_HI after bit 4 has been written
    w0 = wr_cnt; dn0 = done_cnt;
    launch(1, 9);
    for (int i = 0; i < 60 && (wr_cnt - w0) < 5; i++) tick();
    abort = 1;
    tick();
    abort = 0;
    tick();
    chk("t4_ready", ready, 1);
    chk("t4_scanout_low", scanout_clk, 0);
    chk("t4_sample_low", sample_clk, 0);
    for (int i = 0; i < 40; i++) tick();
    chk("t4_writes", wr_cnt - w0, 5);
    chk("t4_no_done", done_cnt - dn0, 0);
    w0 = wr_cnt;
    run(1, 11, 60);
    chk("t4_rerun_writes", wr_cnt - w0, 8);

    // abort together with start in IDLE: start ignored
    s0 = sclk_rise;
    start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    tick();
    chk("idle_abort_ready", ready, 1);
    chk("idle_abort_no_run", sclk_rise - s0, 0);

    // 5: repeated starts and num_samples changes while busy
    w0 = wr_cnt; dn0 = done_cnt;
    launch(2, 3);
    for (int i = 0; i < 100 && done_cnt == dn0; i++) begin
      start = (i % 3 == 0); num_samples = 5'd7;
      tick();
    end
    start = 0;
    chk("t5_writes", wr_cnt - w0, 16);
    chk("t5_done_cycle", done_cyc - c0, 67);
    chk("t5_last_idx", last_si, 1);
    tick();
    launch(1, 4);
    for (int i = 0; i < 15; i++) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("t5_rst_ready", ready, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_addr", bit_addr, 0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_sclk", sample_clk, 0);
    for (int i = 0; i < 3; i++) tick();

    // 6: default depth, HALF_PERIOD=1
    start2 = 1;
    tick();
    start2 = 0;
    for (int i = 0; i < 2200 && d2_cnt == 0; i++) tick();
    chk("t6_done", d2_cnt, 1);
    chk("t6_writes", w2, 1008);
    chk("t6_scan_rises", r2, 1007);
    chk("t6_last_bit", last_ba2, 1007);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
Parametrised successor to the single-shot COBI scan-chain readout engine. Drives sample_clk and scanout_clk for NUM_CHAINS parallel scan chains. Runs 1..MAX_SAMPLES back-to-back sample/shift passes per start, with a programmable scanout-clock divider and synchronous abort. Each captured NUM_CHAINS-bit slice is emitted as a BRAM write: address {sample_idx, bit_addr}, data out_data, enable out_valid.

Parameters:
NUM_CHAINS, 4, number of parallel scan chains (one data bit each per shift)
SCAN_CHAIN_DEPTH, 1008, bits per chain (504 * chips per chain), >=1
HALF_PERIOD, 2, clk cycles per scanout_clk half period, >=1
SAMPLE_PULSE, 4, clk cycles sample_clk is held high, >=1
MAX_SAMPLES, 16, maximum samples per run, power of two, >=2

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  run request, sampled only when ready=1
num_samples  in  $clog2(MAX_SAMPLES)+1  requested sample count, latched on accepted start
abort  in  1  synchronous abort
scanout_data  in  NUM_CHAINS  serial data from the chains
ready  out  1  idle, will accept start
busy  out  1  run in progress (~ready)
sample_clk  out  1  spin-sample strobe to the chips
scanout_clk  out  1  shift clock to the chips
out_valid  out  1  one-cycle write enable
out_data  out  NUM_CHAINS  captured slice
bit_addr  out  $clog2(SCAN_CHAIN_DEPTH)  bit index of out_data
sample_idx  out  $clog2(MAX_SAMPLES)  sample index of out_data
done  out  1  one-cycle pulse at normal completion

Behaviour:
- Reset (rst_n=0 at a clk edge): ready=1, busy=0. All other outputs 0. State IDLE. Reset overrides everything, including mid-run.
- num_samples handling: 0 becomes 1; values >MAX_SAMPLES clamp to MAX_SAMPLES.
- States: IDLE, SAMPLE, GAP, SHIFT_HI, SHIFT_LO, DONE.
- IDLE: start=1 and abort=0 -> SAMPLE next cycle. ready drops that same next cycle. sample_idx=0.
- SAMPLE: sample_clk=1 for exactly SAMPLE_PULSE cycles, then GAP.
- GAP: sample_clk=0 and scanout_clk=0 for HALF_PERIOD cycles. On the last GAP cycle, capture bit 0.
- SHIFT_HI: scanout_clk=1 for HALF_PERIOD cycles.
- SHIFT_LO: scanout_clk=0 for HALF_PERIOD cycles. On the last cycle, capture the next bit.
- Shift loop: SHIFT_HI/SHIFT_LO repeats SCAN_CHAIN_DEPTH-1 times, giving exactly DEPTH-1 scanout_clk rising edges per sample.
- Capture: registers scanout_data. The following cycle drives out_valid=1 with out_data, bit_addr and sample_idx of that capture. Outputs hold their values while out_valid=0.
- Per-sample length: SAMPLE_PULSE + HALF_PERIOD + (DEPTH-1)*2*HALF_PERIOD cycles.
- End of sample: after the last capture, if more samples remain, increment sample_idx and go to SAMPLE directly. Otherwise go to DONE.
- DONE: done=1 for one cycle, coinciding with the final out_valid. Next cycle IDLE, ready=1.
- start while busy: ignored. num_samples is not re-latched.
- abort=1 in any non-IDLE state: next cycle IDLE, ready=1, sample_clk=0, scanout_clk=0, out_valid=0 (pending write dropped), done=0.
- abort=1 with start=1 in IDLE: start ignored.
- Counters: the bit counter wraps to 0 per sample. The divider counter reloads each phase. No counter overflows for legal parameters.
- Clock outputs are registered and glitch-free: sample_clk and scanout_clk are never high simultaneously.

Decomposition:
- Package cobi_pkg holds:
  - CHIP_SCAN_BITS=504
  - scan state enum typedef
  - clog2-with-minimum-1 helper function (for DEPTH=1 / single-sample widths)
- One sub-module, scan_phase_timer: loadable down-counter emitting a last-cycle flag, parametrised by max count. Instanced once and reused for SAMPLE/GAP/SHIFT phases.

Test Plan:
Bench uses a shift-register model of NUM_CHAINS chains. It loads on sample_clk rise and shifts on scanout_clk rise.
1. DEPTH=8, HALF_PERIOD=2, SAMPLE_PULSE=3, num_samples=1, chains preloaded 0xA5/0x3C/0xFF/0x00 -> exactly 8 out_valid, bit_addr 0..7, data matches the model. 7 scanout_clk rises, one 3-cycle sample_clk pulse. done on cycle 34 after start accept, coincident with bit 7. ready=1 next cycle.
2. Same config, num_samples=3, model reloaded with a new pattern per sample_clk -> 24 writes, sample_idx 0,0..,1,..,2. Three sample_clk pulses 33 cycles apart, one done.
3. num_samples=0 -> identical to num_samples=1. num_samples=31 with MAX_SAMPLES=16 -> 16 samples, final sample_idx=15.
4. abort asserted in SHIFT_HI after bit 4 written -> next cycle clocks low, ready=1, no further out_valid, no done. A following start completes a full clean run.
5. start pulsed repeatedly while busy, then rst_n=0 mid-shift for one cycle -> run unaffected by starts. After reset, all outputs are at reset values and ready=1.
6. Defaults (DEPTH=1008, HALF_PERIOD=1) -> 1008 writes per sample, bit_addr ends at 1007, 1007 scanout_clk rises.
